// File: rtl/inst_fetch_ctrl_if.sv
// SRAM-like instruction bus: one request/address phase, one data phase.
interface inst_fetch_ctrl_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;

  modport master (output inst_req, inst_addr,
                  input  inst_addr_ok, inst_rdata, inst_data_ok);
  modport slave  (input  inst_req, inst_addr,
                  output inst_addr_ok, inst_rdata, inst_data_ok);
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch bus master: PC -> single outstanding bus read -> decode.
// Optional FETCH_TIMEOUT_EN adds a wait counter that turns a stuck bus into busError.
module inst_fetch_ctrl #(
  parameter logic [31:0] NOP_INST       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        idStall,
  output logic        pcStall,
  output logic        instValid,
  output logic [31:0] inst,
  output logic [31:0] instPc,
  output logic        addrError,
  output logic        busError,
  inst_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID, S_DROP} state_e;

  state_e      state_q;
  logic [31:0] inst_q;
  logic [31:0] ipc_q;
  logic        aerr_q;
  logic        misalign;
  logic        aok;

  assign misalign     = |pc[1:0];
  assign bus.inst_req  = rst && (state_q == S_REQ) && !misalign;
  assign bus.inst_addr = pc;
  assign aok           = bus.inst_addr_ok && bus.inst_req;

  assign instValid = (state_q == S_VALID);
  assign inst      = inst_q;
  assign instPc    = ipc_q;
  assign addrError = aerr_q;
  assign pcStall   = !rst || (!(instValid && !idStall) && !flush);

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q;
  logic          berr_q;
  logic          tmo;
  assign tmo      = (cnt_q == CW'(TIMEOUT_CYCLES));
  assign busError = berr_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
  assign busError       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_REQ;
      inst_q  <= NOP_INST;
      ipc_q   <= '0;
      aerr_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      berr_q  <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
`ifdef FETCH_TIMEOUT_EN
      cnt_q <= '0;
`endif
      unique case (state_q)
        S_REQ: begin
          if (flush) begin
            if (aok) state_q <= S_DROP;
          end else if (misalign) begin
            state_q <= S_VALID;
            inst_q  <= NOP_INST;
            ipc_q   <= pc;
            aerr_q  <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            berr_q  <= 1'b0;
`endif
          end else if (aok) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            state_q <= bus.inst_data_ok ? S_REQ : S_DROP;
          end else if (bus.inst_data_ok) begin
            state_q <= S_VALID;
            inst_q  <= bus.inst_rdata;
            ipc_q   <= pc;
            aerr_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            berr_q  <= 1'b0;
          end else if (tmo) begin
            state_q <= S_VALID;
            inst_q  <= NOP_INST;
            ipc_q   <= pc;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
`endif
          end
        end
        S_VALID: begin
          if (flush || !idStall) state_q <= S_REQ;
        end
        S_DROP: begin
          // The orphaned response retires the transaction even under a new
          // flush; no request is outstanding afterwards, so waiting longer would hang.
          if (bus.inst_data_ok) begin
            state_q <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
          end else if (tmo) begin
            state_q <= S_REQ;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed, table-driven bench for inst_fetch_ctrl plus a stuck-bus sequence.
module tb_inst_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        flush, idStall;
  logic        pcStall, instValid, addrError, busError;
  logic [31:0] inst, instPc;

  always #5 clk = ~clk;

  inst_fetch_ctrl_if bus ();

  inst_fetch_ctrl dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush), .idStall(idStall),
    .pcStall(pcStall), .instValid(instValid), .inst(inst), .instPc(instPc),
    .addrError(addrError), .busError(busError), .bus(bus)
  );

  typedef struct {
    logic        r;
    logic [31:0] pc;
    logic        fl, ids, aok, dok;
    logic [31:0] rdata;
    logic        e_req, e_stall, e_val;
    logic [31:0] e_inst, e_ipc;
    logic        e_aerr;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;
  int   bad    = 0;
  int   n      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [31:0] p, input logic fl, input logic ids,
                     input logic aok, input logic dok, input logic [31:0] rd,
                     input logic ereq, input logic estall, input logic eval,
                     input logic [31:0] einst, input logic [31:0] eipc, input logic eaerr);
    vec_t v;
    v.r = r; v.pc = p; v.fl = fl; v.ids = ids; v.aok = aok; v.dok = dok; v.rdata = rd;
    v.e_req = ereq; v.e_stall = estall; v.e_val = eval;
    v.e_inst = einst; v.e_ipc = eipc; v.e_aerr = eaerr;
    vq.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [31:0] p, input logic fl, input logic ids,
                       input logic aok, input logic dok, input logic [31:0] rd);
    rst = r; pc = p; flush = fl; idStall = ids;
    bus.inst_addr_ok = aok; bus.inst_data_ok = dok; bus.inst_rdata = rd;
  endtask

  initial begin
    drive(1'b0, 32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);

    // reset and zero-wait back-to-back fetches
    add(0, 32'hBFC00000, 0,0,0,0, 32'h0,        0,1,0, 32'h0,        32'h0,        0);
    add(1, 32'hBFC00000, 0,0,1,0, 32'h0,        1,1,0, 32'h0,        32'h0,        0);
    add(1, 32'hBFC00000, 0,0,0,1, 32'h11111111, 0,1,0, 32'h0,        32'h0,        0);
    add(1, 32'hBFC00000, 0,0,0,0, 32'h0,        0,0,1, 32'h11111111, 32'hBFC00000, 0);
    add(1, 32'hBFC00004, 0,0,1,0, 32'h0,        1,1,0, 32'h11111111, 32'hBFC00000, 0);
    add(1, 32'hBFC00004, 0,0,0,1, 32'h22222222, 0,1,0, 32'h11111111, 32'hBFC00000, 0);
    add(1, 32'hBFC00004, 0,0,0,0, 32'h0,        0,0,1, 32'h22222222, 32'hBFC00004, 0);
    // decode stall for 4 cycles
    add(1, 32'hBFC00000, 0,0,1,0, 32'h0,        1,1,0, 32'h22222222, 32'hBFC00004, 0);
    add(1, 32'hBFC00000, 0,0,0,1, 32'h3C080001, 0,1,0, 32'h22222222, 32'hBFC00004, 0);
    for (int k = 0; k < 4; k++)
      add(1, 32'hBFC00000, 0,1,0,0, 32'h0,      0,1,1, 32'h3C080001, 32'hBFC00000, 0);
    add(1, 32'hBFC00000, 0,0,0,0, 32'h0,        0,0,1, 32'h3C080001, 32'hBFC00000, 0);
    add(1, 32'hBFC00008, 0,0,0,0, 32'h0,        1,1,0, 32'h3C080001, 32'hBFC00000, 0);
    add(1, 32'hBFC00008, 0,0,1,0, 32'h0,        1,1,0, 32'h3C080001, 32'hBFC00000, 0);
    // flush in WAIT, late response dropped
    add(1, 32'hBFC00008, 1,0,0,0, 32'h0,        0,0,0, 32'h3C080001, 32'hBFC00000, 0);
    add(1, 32'hBFC00380, 0,0,0,0, 32'h0,        0,1,0, 32'h3C080001, 32'hBFC00000, 0);
    add(1, 32'hBFC00380, 0,0,0,0, 32'h0,        0,1,0, 32'h3C080001, 32'hBFC00000, 0);
    add(1, 32'hBFC00380, 0,0,0,1, 32'hDEADBEEF, 0,1,0, 32'h3C080001, 32'hBFC00000, 0);
    add(1, 32'hBFC00380, 0,0,1,0, 32'h0,        1,1,0, 32'h3C080001, 32'hBFC00000, 0);
    add(1, 32'hBFC00380, 0,0,0,1, 32'h12345678, 0,1,0, 32'h3C080001, 32'hBFC00000, 0);
    add(1, 32'hBFC00380, 0,0,0,0, 32'h0,        0,0,1, 32'h12345678, 32'hBFC00380, 0);
    // misaligned pc
    add(1, 32'hBFC00002, 0,0,0,0, 32'h0,        0,1,0, 32'h12345678, 32'hBFC00380, 0);
    add(1, 32'hBFC00002, 0,0,0,0, 32'h0,        0,0,1, 32'h0,        32'hBFC00002, 1);
    // reset while in WAIT
    add(1, 32'hBFC00010, 0,0,1,0, 32'h0,        1,1,0, 32'h0,        32'hBFC00002, 1);
    add(0, 32'hBFC00010, 0,0,0,0, 32'h0,        0,1,0, 32'h0,        32'hBFC00002, 1);
    add(1, 32'hBFC00010, 0,0,0,0, 32'h0,        1,1,0, 32'h0,        32'h0,        0);
    // flush with addr_ok -> DROP, flush again in DROP, flush with data_ok, flush in VALID
    add(1, 32'hBFC00010, 1,0,1,0, 32'h0,        1,0,0, 32'h0,        32'h0,        0);
    add(1, 32'hBFC00020, 1,0,0,0, 32'h0,        0,0,0, 32'h0,        32'h0,        0);
    add(1, 32'hBFC00020, 0,0,0,1, 32'hAAAAAAAA, 0,1,0, 32'h0,        32'h0,        0);
    add(1, 32'hBFC00020, 0,0,1,0, 32'h0,        1,1,0, 32'h0,        32'h0,        0);
    add(1, 32'hBFC00020, 1,0,0,1, 32'hBBBBBBBB, 0,0,0, 32'h0,        32'h0,        0);
    add(1, 32'hBFC00030, 0,0,1,0, 32'h0,        1,1,0, 32'h0,        32'h0,        0);
    add(1, 32'hBFC00030, 0,0,0,1, 32'hCCCCCCCC, 0,1,0, 32'h0,        32'h0,        0);
    add(1, 32'hBFC00030, 1,1,0,0, 32'h0,        0,0,1, 32'hCCCCCCCC, 32'hBFC00030, 0);
    add(1, 32'hBFC00040, 0,0,0,0, 32'h0,        1,1,0, 32'hCCCCCCCC, 32'hBFC00030, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].r, vq[i].pc, vq[i].fl, vq[i].ids, vq[i].aok, vq[i].dok, vq[i].rdata);
      #1;
      chk($sformatf("row%0d inst_req", i),  {31'b0, bus.inst_req}, {31'b0, vq[i].e_req});
      chk($sformatf("row%0d pcStall", i),   {31'b0, pcStall},      {31'b0, vq[i].e_stall});
      chk($sformatf("row%0d instValid", i), {31'b0, instValid},    {31'b0, vq[i].e_val});
      chk($sformatf("row%0d inst", i),      inst,                  vq[i].e_inst);
      chk($sformatf("row%0d instPc", i),    instPc,                vq[i].e_ipc);
      chk($sformatf("row%0d addrError", i), {31'b0, addrError},    {31'b0, vq[i].e_aerr});
      chk($sformatf("row%0d busError", i),  {31'b0, busError},     32'h0);
      if (vq[i].e_req)
        chk($sformatf("row%0d inst_addr", i), bus.inst_addr, vq[i].pc);
    end

    // stuck bus: accept the address, never return data
    @(negedge clk);
    drive(1'b1, 32'hBFC00040, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("stuck inst_req", {31'b0, bus.inst_req}, 32'h1);
    @(negedge clk);
    drive(1'b1, 32'hBFC00040, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
`ifdef FETCH_TIMEOUT_EN
    n = 0;
    while (!instValid && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("timeout instValid", {31'b0, instValid}, 32'h1);
    chk("timeout busError",  {31'b0, busError},  32'h1);
    chk("timeout inst",      inst,               32'h0);
    chk("timeout instPc",    instPc,             32'hBFC00040);
`else
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      #1;
      if (!pcStall || instValid || bus.inst_req || busError) bad++;
    end
    chk("stuck hold cycles", bad, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
